sapx_cpu: RTL and testbench
===========================

// Module: sapx_cpu
// PURPOSE
//  Parametrised SAP-class accumulator CPU; next generation of our 8-bit SAP-1 core.
//  Data/address widths are generic; unified program/data RAM gets an external load port.
//  The output register gets a valid/ready handshake so a consumer can stall OUT.
//  Top-level compute core of the trainer design; drives display/UART sinks via out_*.
// PARAMETERS
//  DATA_W  8  accumulator/bus/RAM word width; must be >= ADDR_W+4
//  ADDR_W  4  PC/MAR width; RAM depth = 2**ADDR_W words
// PORTS
//  clk        in   1       single system clock, all state on posedge
//  reset      in   1       asynchronous, active-high reset
//  prog_we    in   1       RAM load strobe
//  prog_addr  in   ADDR_W  RAM load address
//  prog_data  in   DATA_W  RAM load data
//  out_data   out  DATA_W  output register (A at OUT)
//  out_valid  out  1       out_data holds an untransferred value
//  out_ready  in   1       sink accepts out_data when high with out_valid
//  halted     out  1       CPU executed HLT
// BEHAVIOUR
//  Reset: PC, MAR, IR, A, B, flags{C,Z}, stage=0; out_data=0, out_valid=0, halted=0.
//   RAM is not cleared. Reset mid-instruction aborts it; no RAM write occurs.
//  prog_we write takes effect at posedge only while reset=1 or halted=1; ignored otherwise.
//  Instr word: opcode=[DATA_W-1:DATA_W-4], operand=[ADDR_W-1:0]; other bits ignored.
//  Stages: T0 MAR<=PC | T1 IR<=RAM[MAR], PC<=PC+1 (wraps 2**ADDR_W-1->0) | T2..T4 execute.
//  Last execute stage returns stage to T0; cycles per instr incl. fetch:
//   NOP 0000, undefined opcodes: 3 (T2 idle)
//   LDI 0101: T2 A<=zero-ext operand; 3
//   JMP 0110: T2 PC<=operand; 3. JC 0111 / JZ 1000: jump if C / Z set, else NOP; 3
//   LDA 0001: T2 MAR<=op, T3 A<=RAM; 4. STA 0100: T2 MAR<=op, T3 RAM[MAR]<=A; 4
//   ADD 0010 / SUB 0011: T2 MAR<=op, T3 B<=RAM, T4 A<=result, flags<=new; 5
//   OUT 1110: see handshake. HLT 1111: T2 sets halted=1; stage frozen until reset.
//  Arithmetic: DATA_W+1-bit sum. ADD: A+B. SUB: A+~B+1 (C=1 means no borrow).
//   C=bit DATA_W, Z=(result[DATA_W-1:0]==0). Flags change only on ALU ops.
//  OUT handshake: first T2 cycle loads out_data<=A, out_valid<=1. Stage holds at T2
//   while out_valid=1. At posedge with out_valid&out_ready: out_valid<=0, stage->T0.
//   Min 4 cycles with out_ready=1. out_data stable while valid; retained afterwards.
//   out_ready is ignored while out_valid=0.
//  Simultaneous: prog_we to the address being fetched while halted has no effect on
//   execution (halted never fetches).
// CONFIGURATION
//  SAPX_IMM_ALU_EN defined: opcodes 1001 ADI, 1010 SBI.
//   T2 B<=zero-ext operand, T3 A<=A+/-B, flags updated per arithmetic rules; 4 cycles.
//  Not defined: 1001/1010 decode as NOP (3 cycles), no immediate ALU datapath.
// TESTING (DATA_W=8, ADDR_W=4 unless noted)
//  1 Load {LDI 5, ADD F, OUT, HLT}, RAM[F]=3, release reset, out_ready=1
//    -> one out_valid pulse with out_data=0x08; halted=1 at cycle 3+5+4+3; PC=4.
//  2 A=0xFF (LDA), ADD with RAM[F]=1 -> A=0x00, C=1, Z=1; following JC 7 taken: PC=7.
//  3 LDI 3, SUB RAM[F]=3, JZ 9 -> Z=1, C=1, PC=9; SUB of 4 from 3 -> A=0xFF, C=0, Z=0, JZ not taken.
//  4 OUT with out_ready low 6 cycles -> out_valid high, out_data stable, PC frozen;
//    ready high -> transfer in 1 cycle, next fetch follows.
//  5 Assert reset during T3 of STA -> target RAM word unchanged, all regs/outputs 0,
//    program reruns from addr 0; prog_we while running is ignored.
//  6 Fill RAM with NOP, run 17 instructions -> PC wraps 15->0; with SAPX_IMM_ALU_EN,
//    LDI 2, ADI 7 -> A=0x09 in 4 cycles; without it ADI is a 3-cycle NOP, A=0x02.

Source files
------------

// File: rtl/sapx_cpu.sv
// sapx_cpu: parametrised SAP-class accumulator CPU with a unified program/data RAM,
// an external RAM load port (honoured only in reset or halt), and a valid/ready
// output register. Instructions are fetched in T0/T1 and executed in T2..T4.
// Optional feature macro: SAPX_IMM_ALU_EN adds ADI (1001) and SBI (1010)
// immediate arithmetic. Without it those opcodes decode as 3-cycle NOPs.
module sapx_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  typedef enum logic [2:0] {
    ST_T0 = 3'd0,
    ST_T1 = 3'd1,
    ST_T2 = 3'd2,
    ST_T3 = 3'd3,
    ST_T4 = 3'd4
  } stage_e;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
`ifdef SAPX_IMM_ALU_EN
  localparam logic [3:0] OP_ADI = 4'b1001;
  localparam logic [3:0] OP_SBI = 4'b1010;
`endif
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  stage_e            stage_q, stage_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] mem_rd_s;
  logic              sta_we_s;
  logic              load_en_s;
  logic [3:0]        opcode_s;
  logic [ADDR_W-1:0] operand_s;
  logic [DATA_W-1:0] imm_s;
  logic              sub_s;
  logic [DATA_W:0]   sum_s;

  assign opcode_s  = ir_q[DATA_W-1 -: 4];
  assign operand_s = ir_q[ADDR_W-1:0];
  assign imm_s     = {{(DATA_W-ADDR_W){1'b0}}, operand_s};
  assign mem_rd_s  = mem_q[mar_q];
  // External loads are only honoured while the core is parked (reset or halted).
  assign load_en_s = prog_we & (reset | halted_q);

`ifdef SAPX_IMM_ALU_EN
  assign sub_s = (opcode_s == OP_SUB) || (opcode_s == OP_SBI);
`else
  assign sub_s = (opcode_s == OP_SUB);
`endif
  // Subtraction is A + ~B + 1, so the carry out means "no borrow".
  assign sum_s = {1'b0, a_q} + {1'b0, (sub_s ? ~b_q : b_q)} + {{DATA_W{1'b0}}, sub_s};

  // RAM write port: external load has priority, otherwise STA in T3; RAM has no reset.
  always_ff @(posedge clk) begin
    if (load_en_s) begin
      mem_q[prog_addr] <= prog_data;
    end else if (sta_we_s) begin
      mem_q[mar_q] <= a_q;
    end
  end

  // Architectural state registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q     <= ST_T0;
      pc_q        <= {ADDR_W{1'b0}};
      mar_q       <= {ADDR_W{1'b0}};
      ir_q        <= {DATA_W{1'b0}};
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  // Stage sequencer and datapath next-state; a halted core holds everything.
  always_comb begin
    stage_d     = stage_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    sta_we_s    = 1'b0;
    if (halted_q) begin
      stage_d = stage_q;
    end else begin
      case (stage_q)
        ST_T0: begin
          mar_d   = pc_q;
          stage_d = ST_T1;
        end
        ST_T1: begin
          ir_d    = mem_rd_s;
          pc_d    = pc_q + ADDR_W'(1);
          stage_d = ST_T2;
        end
        ST_T2: begin
          stage_d = ST_T0;
          case (opcode_s)
            OP_LDI: a_d = imm_s;
            OP_JMP: pc_d = operand_s;
            OP_JC: begin
              if (c_q) pc_d = operand_s;
              else     pc_d = pc_q;
            end
            OP_JZ: begin
              if (z_q) pc_d = operand_s;
              else     pc_d = pc_q;
            end
            OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
              mar_d   = operand_s;
              stage_d = ST_T3;
            end
`ifdef SAPX_IMM_ALU_EN
            OP_ADI, OP_SBI: begin
              b_d     = imm_s;
              stage_d = ST_T3;
            end
`endif
            OP_OUT: begin
              // Load once, then park in T2 until the sink takes the value.
              if (!out_valid_q) begin
                out_data_d  = a_q;
                out_valid_d = 1'b1;
                stage_d     = ST_T2;
              end else if (out_ready) begin
                out_valid_d = 1'b0;
                stage_d     = ST_T0;
              end else begin
                stage_d     = ST_T2;
              end
            end
            OP_HLT: begin
              halted_d = 1'b1;
              stage_d  = ST_T2;
            end
            default: stage_d = ST_T0;
          endcase
        end
        ST_T3: begin
          stage_d = ST_T0;
          case (opcode_s)
            OP_LDA: a_d = mem_rd_s;
            OP_STA: sta_we_s = 1'b1;
            OP_ADD, OP_SUB: begin
              b_d     = mem_rd_s;
              stage_d = ST_T4;
            end
`ifdef SAPX_IMM_ALU_EN
            OP_ADI, OP_SBI: begin
              a_d = sum_s[DATA_W-1:0];
              c_d = sum_s[DATA_W];
              z_d = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
            end
`endif
            default: stage_d = ST_T0;
          endcase
        end
        ST_T4: begin
          a_d     = sum_s[DATA_W-1:0];
          c_d     = sum_s[DATA_W];
          z_d     = (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
          stage_d = ST_T0;
        end
        default: stage_d = ST_T0;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_sapx_cpu.sv
// tb_sapx_cpu: table of whole programs (RAM image, expected OUT values and
// cycles-to-halt) plus hand-written sequences for OUT stalling, reset during
// STA and RAM loading while halted.
module tb_sapx_cpu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [7:0] prog_data = 8'd0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       halted;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [0:15][7:0] mem;
    logic [7:0]       cycles;
    logic [1:0]       n_out;
    logic [7:0]       o0;
    logic [7:0]       o1;
  } vec_t;

  vec_t       tbl [12];
  logic [7:0] outs [$];
  int         cyc;

  sapx_cpu #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [127:0] m, input int c, input int n,
                              input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.mem    = m;
    v.cycles = 8'(c);
    v.n_out  = 2'(n);
    v.o0     = a;
    v.o1     = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold reset and write a full 16-word image; leaves reset asserted.
  task automatic load_img(input logic [0:15][7:0] m);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = m[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  // From a negedge with reset released: count edges until halted, capture transfers.
  task automatic run(input int max_cyc);
    outs.delete();
    cyc = 0;
    while (cyc < max_cyc) begin
      if (out_valid && out_ready) outs.push_back(out_data);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (halted) break;
    end
  endtask

  task automatic check_run(input string tag, input vec_t v);
    logic [7:0] act;
    chk({tag, " cycles"}, 32'(cyc), 32'(v.cycles));
    chk({tag, " halted"}, 32'(halted), 32'd1);
    chk({tag, " n_out"}, 32'(outs.size()), 32'(v.n_out));
    for (int k = 0; k < int'(v.n_out); k++) begin
      act = (k < outs.size()) ? outs[k] : 8'hxx;
      chk({tag, $sformatf(" out%0d", k)}, 32'(act), 32'((k == 0) ? v.o0 : v.o1));
    end
  endtask

  initial begin
    tbl[0]  = mk(128'h552FE0F0_00000000_00000000_00000003, 15, 1, 8'h08, 8'h00); // LDI/ADD/OUT/HLT
    tbl[1]  = mk(128'h1E2F7751_E0F0008B_52E0F0E0_F000FF01, 22, 1, 8'h00, 8'h00); // FF+1: C,Z, JC/JZ taken
    tbl[2]  = mk(128'h533F8951_E0F00000_007C52F0_E0F00003, 21, 1, 8'h00, 8'h00); // 3-3: Z=1, C=1
    tbl[3]  = mk(128'h533F8979_E0F00000_0051E0F0_00000004, 21, 1, 8'hFF, 8'h00); // 3-4: borrow, no jumps
    tbl[4]  = mk(128'h5F2E75F0_00E0F000_00000000_0000F500, 18, 1, 8'h04, 8'h00); // 0F+F5 carry
    tbl[5]  = mk(128'h594E501E_E0F00000_00000000_00000000, 21, 1, 8'h09, 8'h00); // STA then LDA
    tbl[6]  = mk(128'h5AE055E0_F0000000_00000000_00000000, 17, 2, 8'h0A, 8'h05); // two OUTs
    tbl[7]  = mk(128'h54B0C5D0_E0F00000_00000000_00000000, 19, 1, 8'h04, 8'h00); // undefined opcodes
    tbl[8]  = mk(128'h64515151_57E0F000_00000000_00000000, 13, 1, 8'h07, 8'h00); // JMP
    tbl[9]  = mk(128'hE03F4000_00000000_00000000_00000010, 56, 1, 8'h00, 8'h00); // 17 instr, PC wraps
`ifdef SAPX_IMM_ALU_EN
    tbl[10] = mk(128'h5297E0F0_00000000_00000000_00000000, 14, 1, 8'h09, 8'h00); // LDI 2, ADI 7
    tbl[11] = mk(128'h52A3E0F0_00000000_00000000_00000000, 14, 1, 8'hFF, 8'h00); // LDI 2, SBI 3
`else
    tbl[10] = mk(128'h5297E0F0_00000000_00000000_00000000, 13, 1, 8'h02, 8'h00); // ADI is NOP
    tbl[11] = mk(128'h52A3E0F0_00000000_00000000_00000000, 13, 1, 8'h02, 8'h00); // SBI is NOP
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst out_data", 32'(out_data), 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst halted", 32'(halted), 32'h0);

    // Table of whole programs
    for (int t = 0; t < 12; t++) begin
      load_img(tbl[t].mem);
      out_ready = 1'b1;
      reset = 1'b0;
      run(200);
      check_run($sformatf("vec%0d", t), tbl[t]);
    end

    // OUT stalled by the sink for 6 cycles
    load_img(128'h56E0F000_00000000_00000000_00000000);
    out_ready = 1'b0;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall pre valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("stall valid", 32'(out_valid), 32'h1);
    chk("stall data", 32'(out_data), 32'h06);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall hold valid %0d", i), 32'(out_valid), 32'h1);
      chk($sformatf("stall hold data %0d", i), 32'(out_data), 32'h06);
      chk($sformatf("stall hold halted %0d", i), 32'(halted), 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall xfer valid", 32'(out_valid), 32'h0);
    chk("stall retained data", 32'(out_data), 32'h06);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stall halt early", 32'(halted), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("stall halt", 32'(halted), 32'h1);

    // Reset during STA T3; prog_we while running is ignored
    load_img(128'h59E04E1E_E0F00000_00000000_00003300);
    out_ready = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 4'hE;
    prog_data = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("sta pre-reset out_data", 32'(out_data), 32'h09);
    reset = 1'b1;
    #1;
    chk("sta rst out_data", 32'(out_data), 32'h0);
    chk("sta rst out_valid", 32'(out_valid), 32'h0);
    chk("sta rst halted", 32'(halted), 32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      prog_we = 1'b1;
      prog_addr = 4'(i);
      prog_data = (i == 0) ? 8'h1E : ((i == 1) ? 8'hE0 : 8'hF0);
      @(negedge clk);
    end
    prog_we = 1'b0;
    reset = 1'b0;
    run(200);
    check_run("sta abort", mk(128'h0, 11, 1, 8'h33, 8'h00));

    // RAM load while halted, then rerun
    prog_we = 1'b1;
    prog_addr = 4'hE;
    prog_data = 8'h77;
    @(negedge clk);
    prog_we = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run(200);
    check_run("halt load", mk(128'h0, 11, 1, 8'h77, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
